// File: rtl/user_wb_slave_router_if.sv
// Wishbone bundle between the management slave port and the user peripherals.
// The slave modport is the router's view; the master modport drives the router.
interface user_wb_slave_router_if #(
    parameter int NUM_SLV = 4
);
    logic                   wbs_cyc_i;
    logic                   wbs_stb_i;
    logic                   wbs_we_i;
    logic [3:0]             wbs_sel_i;
    logic [31:0]            wbs_adr_i;
    logic [31:0]            wbs_dat_i;
    logic                   wbs_ack_o;
    logic [31:0]            wbs_dat_o;
    logic [NUM_SLV-1:0]     s_cyc_o;
    logic [NUM_SLV-1:0]     s_stb_o;
    logic                   s_we_o;
    logic [3:0]             s_sel_o;
    logic [31:0]            s_adr_o;
    logic [31:0]            s_dat_o;
    logic [32*NUM_SLV-1:0]  s_dat_i;
    logic [NUM_SLV-1:0]     s_ack_i;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  s_dat_i, s_ack_i
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output s_dat_i, s_ack_i
    );
endinterface

// File: rtl/user_wb_slave_router.sv
// Routes the user-area management Wishbone slave to NUM_SLV peripherals, one
// transaction at a time, with a per-access timeout and error completion.
module user_wb_slave_router #(
    parameter int          NUM_SLV   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          SPAN_LOG2 = 16,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    user_wb_slave_router_if.slave         bus,
    output logic                          err_irq_o,
    output logic [7:0]                    err_cnt_o
);
    localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int HI_LSB = SPAN_LOG2 + IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_ACK  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state;
    logic [15:0]          r_cnt;
    logic [15:0]          w_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx;
    logic                 r_we;
    logic                 w_we;
    logic [3:0]           r_sel;
    logic [3:0]           w_sel;
    logic [SPAN_LOG2-1:0] r_adr;
    logic [SPAN_LOG2-1:0] w_adr;
    logic [31:0]          r_wdat;
    logic [31:0]          w_wdat;
    logic [NUM_SLV-1:0]   r_strb;
    logic [NUM_SLV-1:0]   w_strb;
    logic                 r_ack;
    logic                 w_ack;
    logic [31:0]          r_rdat;
    logic [31:0]          w_rdat;
    logic                 r_irq;
    logic                 w_irq;
    logic [7:0]           r_err_cnt;
    logic [7:0]           w_err_cnt;

    logic                 w_hit;
    logic                 w_mapped;
    logic [IDX_W-1:0]     w_idx_in;
    logic [NUM_SLV-1:0]   w_onehot;
    logic                 w_slv_ack;
    logic [31:0]          w_slv_dat;

    // Address decode of the incoming request and mux of the selected slave's response.
    always_comb begin
        w_hit     = (bus.wbs_adr_i[31:HI_LSB] == BASE_ADDR[31:HI_LSB]);
        w_idx_in  = bus.wbs_adr_i[SPAN_LOG2 +: IDX_W];
        w_mapped  = w_hit && ({{(32-IDX_W){1'b0}}, w_idx_in} < 32'(NUM_SLV));
        w_onehot  = '0;
        w_slv_ack = 1'b0;
        w_slv_dat = 32'h0000_0000;
        for (int k = 0; k < NUM_SLV; k++) begin
            w_onehot[k] = (w_idx_in == IDX_W'(k));
            // Acks from slaves other than the latched target never complete a cycle.
            w_slv_ack   = w_slv_ack | ((r_idx == IDX_W'(k)) & bus.s_ack_i[k]);
            w_slv_dat   = w_slv_dat | ({32{r_idx == IDX_W'(k)}} & bus.s_dat_i[32*k +: 32]);
        end
    end

    // Next-state and next-output logic of the transaction sequencer.
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_idx     = r_idx;
        w_we      = r_we;
        w_sel     = r_sel;
        w_adr     = r_adr;
        w_wdat    = r_wdat;
        w_strb    = r_strb;
        w_ack     = 1'b0;
        w_rdat    = 32'h0000_0000;
        w_irq     = 1'b0;
        w_err_cnt = r_err_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.wbs_cyc_i && bus.wbs_stb_i && !r_ack) begin
                    w_idx  = w_idx_in;
                    w_we   = bus.wbs_we_i;
                    w_sel  = bus.wbs_sel_i;
                    w_adr  = bus.wbs_adr_i[SPAN_LOG2-1:0];
                    w_wdat = bus.wbs_dat_i;
                    w_cnt  = 16'd0;
                    if (w_mapped) begin
                        w_strb  = w_onehot;
                        w_state = ST_FWD;
                    end else begin
                        w_strb  = '0;
                        w_state = ST_ERR;
                    end
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_FWD: begin
                if (!bus.wbs_cyc_i) begin
                    w_strb  = '0;
                    w_state = ST_IDLE;
                end else if (w_slv_ack) begin
                    w_strb  = '0;
                    w_ack   = 1'b1;
                    w_rdat  = r_we ? 32'h0000_0000 : w_slv_dat;
                    w_state = ST_ACK;
                end else if (r_cnt == 16'(TIMEOUT - 1)) begin
                    w_strb  = '0;
                    w_state = ST_ERR;
                end else begin
                    w_cnt   = r_cnt + 16'd1;
                end
            end
            ST_ACK: begin
                w_state = ST_IDLE;
            end
            ST_ERR: begin
                w_ack     = 1'b1;
                w_rdat    = ERR_DATA;
                w_irq     = 1'b1;
                w_err_cnt = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
                w_state   = ST_ACK;
            end
            default: begin
                w_strb  = '0;
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset has priority over every event.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 16'd0;
            r_idx     <= '0;
            r_we      <= 1'b0;
            r_sel     <= 4'h0;
            r_adr     <= '0;
            r_wdat    <= 32'h0000_0000;
            r_strb    <= '0;
            r_ack     <= 1'b0;
            r_rdat    <= 32'h0000_0000;
            r_irq     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_idx     <= w_idx;
            r_we      <= w_we;
            r_sel     <= w_sel;
            r_adr     <= w_adr;
            r_wdat    <= w_wdat;
            r_strb    <= w_strb;
            r_ack     <= w_ack;
            r_rdat    <= w_rdat;
            r_irq     <= w_irq;
            r_err_cnt <= w_err_cnt;
        end
    end

    assign bus.wbs_ack_o = r_ack;
    assign bus.wbs_dat_o = r_rdat;
    assign bus.s_cyc_o   = r_strb;
    assign bus.s_stb_o   = r_strb;
    assign bus.s_we_o    = r_we;
    assign bus.s_sel_o   = r_sel;
    assign bus.s_adr_o   = {{(32-SPAN_LOG2){1'b0}}, r_adr};
    assign bus.s_dat_o   = r_wdat;
    assign err_irq_o     = r_irq;
    assign err_cnt_o     = r_err_cnt;
endmodule

// File: tb/tb_user_wb_slave_router.sv
// Directed bench for user_wb_slave_router: routing, writes, unmapped and timeout
// errors, spurious acks, abort, reset mid-transaction and error-count saturation.
module tb_user_wb_slave_router;
    logic       clk;
    logic       rst;
    logic       irq;
    logic [7:0] ecnt;
    int         n_cmp;
    int         n_bad;

    user_wb_slave_router_if #(.NUM_SLV(4)) bus ();

    user_wb_slave_router #(
        .NUM_SLV(4), .BASE_ADDR(32'h3000_0000), .SPAN_LOG2(16),
        .TIMEOUT(255), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus),
        .err_irq_o(irq),
        .err_cnt_o(ecnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                       input logic [31:0] dat);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
    endtask

    task automatic release_bus();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0 || bus.s_stb_o !== 4'h0 ||
            bus.s_cyc_o !== 4'h0 || bus.s_we_o !== 1'b0 || bus.s_sel_o !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_bus: ack=%b dat=%h stb=%b cyc=%b we=%b sel=%h, required all 0",
                     bus.wbs_ack_o, bus.wbs_dat_o, bus.s_stb_o, bus.s_cyc_o, bus.s_we_o, bus.s_sel_o);
        end
        n_cmp++;
        if (bus.s_adr_o !== 32'h0 || bus.s_dat_o !== 32'h0 || irq !== 1'b0 || ecnt !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_misc: adr=%h sdat=%h irq=%b cnt=%0d, required all 0",
                     bus.s_adr_o, bus.s_dat_o, irq, ecnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        req(32'h3001_0010, 1'b0, 4'hF, 32'h0);
        tick();
        n_cmp++;
        if (bus.s_stb_o !== 4'b0010 || bus.s_cyc_o !== 4'b0010 || bus.s_adr_o !== 32'h10 ||
            bus.s_we_o !== 1'b0 || bus.wbs_ack_o !== 1'b0) begin
            n_bad++;
            $display("FAIL read_fwd: stb=%b cyc=%b adr=%h we=%b ack=%b, required 0010 0010 10 0 0",
                     bus.s_stb_o, bus.s_cyc_o, bus.s_adr_o, bus.s_we_o, bus.wbs_ack_o);
        end
        tick();
        tick();
        bus.s_ack_i        = 4'b0010;
        bus.s_dat_i[63:32] = 32'h1234_5678;
        tick();
        bus.s_ack_i = 4'b0000;
        n_cmp++;
        if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 32'h1234_5678 || bus.s_stb_o !== 4'h0) begin
            n_bad++;
            $display("FAIL read_ack: ack=%b dat=%h stb=%b, required 1 12345678 0000",
                     bus.wbs_ack_o, bus.wbs_dat_o, bus.s_stb_o);
        end
        release_bus();
        tick();
        n_cmp++;
        if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0) begin
            n_bad++;
            $display("FAIL read_done: ack=%b dat=%h, required 0 00000000", bus.wbs_ack_o, bus.wbs_dat_o);
        end
    endtask

    task automatic test_write();
        bus.s_dat_i[127:96] = 32'h5555_AAAA;
        req(32'h3003_0004, 1'b1, 4'b1100, 32'hA5A5_0000);
        tick();
        n_cmp++;
        if (bus.s_stb_o !== 4'b1000 || bus.s_we_o !== 1'b1 || bus.s_dat_o !== 32'hA5A5_0000 ||
            bus.s_sel_o !== 4'b1100 || bus.s_adr_o !== 32'h4) begin
            n_bad++;
            $display("FAIL write_fwd: stb=%b we=%b sdat=%h sel=%b adr=%h, required 1000 1 a5a50000 1100 4",
                     bus.s_stb_o, bus.s_we_o, bus.s_dat_o, bus.s_sel_o, bus.s_adr_o);
        end
        bus.s_ack_i = 4'b1000;
        tick();
        bus.s_ack_i = 4'b0000;
        n_cmp++;
        if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 32'h0 || bus.s_stb_o !== 4'h0) begin
            n_bad++;
            $display("FAIL write_ack: ack=%b dat=%h stb=%b, required 1 00000000 0000",
                     bus.wbs_ack_o, bus.wbs_dat_o, bus.s_stb_o);
        end
        release_bus();
        tick();
    endtask

    task automatic test_unmapped();
        req(32'h3010_0000, 1'b0, 4'hF, 32'h0);
        tick();
        n_cmp++;
        if (bus.s_stb_o !== 4'h0 || bus.wbs_ack_o !== 1'b0) begin
            n_bad++;
            $display("FAIL unmapped_c1: stb=%b ack=%b, required 0000 0", bus.s_stb_o, bus.wbs_ack_o);
        end
        tick();
        n_cmp++;
        if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 32'hDEAD_BEEF || irq !== 1'b1 ||
            ecnt !== 8'd1 || bus.s_stb_o !== 4'h0) begin
            n_bad++;
            $display("FAIL unmapped_c2: ack=%b dat=%h irq=%b cnt=%0d stb=%b, required 1 deadbeef 1 1 0000",
                     bus.wbs_ack_o, bus.wbs_dat_o, irq, ecnt, bus.s_stb_o);
        end
        release_bus();
        tick();
        n_cmp++;
        if (bus.wbs_ack_o !== 1'b0 || irq !== 1'b0 || ecnt !== 8'd1) begin
            n_bad++;
            $display("FAIL unmapped_c3: ack=%b irq=%b cnt=%0d, required 0 0 1", bus.wbs_ack_o, irq, ecnt);
        end
    endtask

    task automatic test_timeout();
        int  stb_cycles;
        bit  got_ack;
        stb_cycles = 0;
        got_ack    = 1'b0;
        req(32'h3000_0000, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 400 && !got_ack; i++) begin
            tick();
            if (bus.s_stb_o[0] === 1'b1) stb_cycles++;
            if (bus.wbs_ack_o === 1'b1) got_ack = 1'b1;
        end
        n_cmp++;
        if (!got_ack) begin
            n_bad++;
            $display("FAIL timeout_bound: no ack within 400 cycles, required ack");
        end
        n_cmp++;
        if (stb_cycles != 255) begin
            n_bad++;
            $display("FAIL timeout_stb_len: strobe held %0d cycles, required 255", stb_cycles);
        end
        n_cmp++;
        if (bus.wbs_dat_o !== 32'hDEAD_BEEF || irq !== 1'b1 || ecnt !== 8'd2) begin
            n_bad++;
            $display("FAIL timeout_err: dat=%h irq=%b cnt=%0d, required deadbeef 1 2",
                     bus.wbs_dat_o, irq, ecnt);
        end
        release_bus();
        tick();
        bus.s_ack_i = 4'b0001;
        tick();
        tick();
        n_cmp++;
        if (bus.wbs_ack_o !== 1'b0 || bus.s_stb_o !== 4'h0 || ecnt !== 8'd2) begin
            n_bad++;
            $display("FAIL timeout_late_ack: ack=%b stb=%b cnt=%0d, required 0 0000 2",
                     bus.wbs_ack_o, bus.s_stb_o, ecnt);
        end
        bus.s_ack_i = 4'b0000;
        tick();
    endtask

    task automatic test_spurious_and_abort();
        bit early;
        early = 1'b0;
        bus.s_dat_i[31:0]  = 32'h0BAD_0000;
        bus.s_dat_i[95:64] = 32'hCAFE_0002;
        req(32'h3002_0008, 1'b0, 4'hF, 32'h0);
        tick();
        bus.s_ack_i = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.wbs_ack_o !== 1'b0 || bus.s_stb_o !== 4'b0100) early = 1'b1;
        end
        n_cmp++;
        if (early) begin
            n_bad++;
            $display("FAIL spurious_ignored: ack=%b stb=%b, required 0 0100", bus.wbs_ack_o, bus.s_stb_o);
        end
        bus.s_ack_i = 4'b0100;
        tick();
        bus.s_ack_i = 4'b0000;
        n_cmp++;
        if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 32'hCAFE_0002) begin
            n_bad++;
            $display("FAIL spurious_done: ack=%b dat=%h, required 1 cafe0002", bus.wbs_ack_o, bus.wbs_dat_o);
        end
        release_bus();
        tick();

        req(32'h3001_0000, 1'b0, 4'hF, 32'h0);
        tick();
        n_cmp++;
        if (bus.s_stb_o !== 4'b0010) begin
            n_bad++;
            $display("FAIL abort_fwd: stb=%b, required 0010", bus.s_stb_o);
        end
        release_bus();
        tick();
        n_cmp++;
        if (bus.s_stb_o !== 4'h0 || bus.s_cyc_o !== 4'h0 || bus.wbs_ack_o !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_drop: stb=%b cyc=%b ack=%b, required 0000 0000 0",
                     bus.s_stb_o, bus.s_cyc_o, bus.wbs_ack_o);
        end
        tick();
        n_cmp++;
        if (bus.wbs_ack_o !== 1'b0 || irq !== 1'b0 || ecnt !== 8'd2) begin
            n_bad++;
            $display("FAIL abort_quiet: ack=%b irq=%b cnt=%0d, required 0 0 2", bus.wbs_ack_o, irq, ecnt);
        end
    endtask

    task automatic test_reset_fwd_and_saturation();
        bit seen;
        req(32'h3001_0000, 1'b1, 4'h3, 32'h7777_8888);
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (bus.s_stb_o !== 4'h0 || bus.s_we_o !== 1'b0 || bus.s_sel_o !== 4'h0 ||
            bus.s_dat_o !== 32'h0 || bus.wbs_ack_o !== 1'b0 || ecnt !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_in_fwd: stb=%b we=%b sel=%h sdat=%h ack=%b cnt=%0d, required all 0",
                     bus.s_stb_o, bus.s_we_o, bus.s_sel_o, bus.s_dat_o, bus.wbs_ack_o, ecnt);
        end
        release_bus();
        rst = 1'b0;
        tick();
        for (int n = 1; n <= 300; n++) begin
            seen = 1'b0;
            req(32'h4000_0000, 1'b0, 4'hF, 32'h0);
            for (int c = 0; c < 4 && !seen; c++) begin
                tick();
                if (bus.wbs_ack_o === 1'b1) seen = 1'b1;
            end
            if (!seen) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sat_bound: access %0d got no ack within 4 cycles", n);
            end
            release_bus();
            tick();
            if (n == 254 || n == 255 || n == 300) begin
                n_cmp++;
                if (ecnt !== ((n >= 255) ? 8'd255 : 8'd254)) begin
                    n_bad++;
                    $display("FAIL sat_count: after %0d errors cnt=%0d, required %0d",
                             n, ecnt, (n >= 255) ? 255 : 254);
                end
            end
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst           = 1'b1;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
        bus.s_dat_i   = '0;
        bus.s_ack_i   = 4'h0;
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_timeout();
        test_spurious_and_abort();
        test_reset_fwd_and_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
